kbd_reg_file: RTL and testbench

- Parametrised successor to the single-port character register file.
- Stores DEPTH words of DATA_W bits.
- Provides two registered read ports: port A for the control side, port B for the VGA text scan-out.
- Supports direct addressed writes, plus a keyboard-style append (push) and backspace (pop) mode with an internal write pointer.
- After reset or on request, clears memory with a multi-cycle sweep, so the storage can infer to block RAM.

---
 rtl/kbd_reg_file_pkg.sv | 13 +
 rtl/kbd_reg_file_if.sv | 33 +++
 rtl/kbd_reg_file_clear_seq.sv | 37 +++
 rtl/kbd_reg_file.sv | 73 +++++++
 tb/tb_kbd_reg_file.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/kbd_reg_file_pkg.sv
// regfile_pkg: shared types, defaults and helpers for the character register file
// and the VGA text engine.
package regfile_pkg;
    typedef enum logic {IDLE, CLEAR} state_t;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF = 16;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/kbd_reg_file_if.sv
// kbd_reg_file_if: request, read and status bundle of the keyboard register file.
interface kbd_reg_file_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    localparam int AW = clog2(DEPTH);
    logic wr_en;
    logic [AW-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic push;
    logic pop;
    logic clr_req;
    logic [AW-1:0] rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic [AW-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic [AW-1:0] wr_ptr;
    logic [AW:0] count;
    logic full;
    logic empty;
    logic busy;
    logic err;
    modport master (
        output wr_en, wr_addr, wr_data, push, pop, clr_req, rd_addr_a, rd_addr_b,
        input rd_data_a, rd_data_b, wr_ptr, count, full, empty, busy, err
    );
    modport slave (
        input wr_en, wr_addr, wr_data, push, pop, clr_req, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, wr_ptr, count, full, empty, busy, err
    );
endinterface

// File: rtl/kbd_reg_file_clear_seq.sv
// rf_clear_seq: IDLE/CLEAR sequencer that sweeps every entry to zero, one per cycle,
// after reset or on a clear request.
module rf_clear_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW = clog2(DEPTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_req,
    output logic busy,
    output logic clr_we,
    output logic [AW-1:0] clr_addr
);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    state_t state, state_n;
    logic [AW-1:0] idx, idx_n;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            idx <= '0;
        end else begin
            state <= state_n;
            idx <= idx_n;
        end
    end
    always_comb begin
        state_n = (state == IDLE) ? (clr_req ? CLEAR : IDLE) : (idx == LAST ? IDLE : CLEAR);
        idx_n = (state == IDLE) ? '0 : idx + AW'(1);
    end
    always_comb begin
        busy = state == CLEAR;
        clr_we = state == CLEAR;
        clr_addr = idx;
    end
endmodule

// File: rtl/kbd_reg_file.sv
// kbd_reg_file: dual-read-port character store with direct writes, keyboard-style
// push/pop append and a multi-cycle clear sweep.
module kbd_reg_file
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input logic clk,
    input logic rst,
    kbd_reg_file_if.slave bus
);
    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] DEP = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE = (AW + 1)'(1);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0] count;
    logic [AW-1:0] wr_ptr, clr_addr, waddr;
    logic [DATA_W-1:0] wdata;
    logic busy, clr_we, full, empty, req, do_push, do_pop, do_wr, we, err_n;
    rf_clear_seq #(.DEPTH(DEPTH)) u_clear (
        .clk(clk),
        .rst(rst),
        .clr_req(bus.clr_req),
        .busy(busy),
        .clr_we(clr_we),
        .clr_addr(clr_addr)
    );
    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < DEP;
    endfunction
    // Write-first: a read of the address being written this cycle sees the new value.
    function automatic logic [DATA_W-1:0] rd_val(input logic [AW-1:0] a);
        return (busy || !in_range(a)) ? '0 : (we && waddr == a) ? wdata : mem[a];
    endfunction
    always_comb begin
        wr_ptr = count[AW-1:0];
        full = count == DEP;
        empty = count == '0;
        req = bus.wr_en | bus.push | bus.pop;
        do_push = !busy && !bus.clr_req && bus.push && !full;
        do_pop = !busy && !bus.clr_req && !bus.push && bus.pop && !empty;
        do_wr = !busy && !bus.clr_req && !bus.push && !bus.pop && bus.wr_en && in_range(bus.wr_addr);
        err_n = (busy || bus.clr_req) ? req :
                bus.push ? (full | bus.pop | bus.wr_en) :
                bus.pop ? (empty | bus.wr_en) :
                (bus.wr_en & !in_range(bus.wr_addr));
        we = clr_we | do_push | do_pop | do_wr;
        waddr = clr_we ? clr_addr : do_push ? wr_ptr : do_pop ? wr_ptr - AW'(1) : bus.wr_addr;
        wdata = (do_push | do_wr) ? bus.wr_data : '0;
    end
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            bus.err <= 1'b0;
            bus.rd_data_a <= '0;
            bus.rd_data_b <= '0;
        end else begin
            count <= (!busy && bus.clr_req) ? '0 : do_push ? count + ONE : do_pop ? count - ONE : count;
            bus.err <= err_n;
            bus.rd_data_a <= rd_val(bus.rd_addr_a);
            bus.rd_data_b <= rd_val(bus.rd_addr_b);
        end
    end
    assign bus.wr_ptr = wr_ptr;
    assign bus.count = count;
    assign bus.full = full;
    assign bus.empty = empty;
    assign bus.busy = busy;
endmodule

// File: tb/tb_kbd_reg_file.sv
// tb_kbd_reg_file: directed and randomized bench for DEPTH=16 and DEPTH=12 instances
// against an array-based reference model.
module tb_kbd_reg_file;
    typedef struct packed {
        logic wr_en;
        logic [3:0] wr_addr;
        logic [7:0] wr_data;
        logic push;
        logic pop;
        logic clr_req;
        logic [3:0] ra;
        logic [3:0] rb;
    } in_t;
    logic clk = 1'b0;
    logic rst;
    in_t inp [2];
    int checks = 0;
    int failures = 0;
    int dep [2] = '{16, 12};
    logic [7:0] m_mem [2][16];
    int m_cnt [2];
    int m_bl [2];
    logic [7:0] e_ra [2];
    logic [7:0] e_rb [2];
    logic e_err [2];
    always #5 clk = ~clk;
    kbd_reg_file_if #(.DATA_W(8), .DEPTH(16)) ia ();
    kbd_reg_file_if #(.DATA_W(8), .DEPTH(12)) ib ();
    kbd_reg_file #(.DATA_W(8), .DEPTH(16)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    kbd_reg_file #(.DATA_W(8), .DEPTH(12)) dut_b (.clk(clk), .rst(rst), .bus(ib));
    assign ia.wr_en = inp[0].wr_en;
    assign ia.wr_addr = inp[0].wr_addr;
    assign ia.wr_data = inp[0].wr_data;
    assign ia.push = inp[0].push;
    assign ia.pop = inp[0].pop;
    assign ia.clr_req = inp[0].clr_req;
    assign ia.rd_addr_a = inp[0].ra;
    assign ia.rd_addr_b = inp[0].rb;
    assign ib.wr_en = inp[1].wr_en;
    assign ib.wr_addr = inp[1].wr_addr;
    assign ib.wr_data = inp[1].wr_data;
    assign ib.push = inp[1].push;
    assign ib.pop = inp[1].pop;
    assign ib.clr_req = inp[1].clr_req;
    assign ib.rd_addr_a = inp[1].ra;
    assign ib.rd_addr_b = inp[1].rb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_rd(input int k, input int a);
        return (a < dep[k]) ? m_mem[k][a] : 8'h00;
    endfunction

    task automatic m_zero(input int k);
        for (int i = 0; i < 16; i++) m_mem[k][i] = 8'h00;
    endtask

    task automatic model_step(input int k);
        in_t x;
        int d;
        logic e;
        x = inp[k];
        d = dep[k];
        e = 1'b0;
        if (rst) begin
            m_cnt[k] = 0;
            m_bl[k] = d;
            m_zero(k);
            e_ra[k] = 0;
            e_rb[k] = 0;
            e_err[k] = 0;
        end else if (m_bl[k] > 0) begin
            e_err[k] = x.wr_en | x.push | x.pop;
            e_ra[k] = 0;
            e_rb[k] = 0;
            m_bl[k]--;
        end else if (x.clr_req) begin
            e_err[k] = x.wr_en | x.push | x.pop;
            e_ra[k] = m_rd(k, int'(x.ra));
            e_rb[k] = m_rd(k, int'(x.rb));
            m_zero(k);
            m_cnt[k] = 0;
            m_bl[k] = d;
        end else begin
            if (x.push) begin
                e = x.pop | x.wr_en;
                if (m_cnt[k] < d) begin
                    m_mem[k][m_cnt[k]] = x.wr_data;
                    m_cnt[k]++;
                end else e = 1'b1;
            end else if (x.pop) begin
                e = x.wr_en;
                if (m_cnt[k] > 0) begin
                    m_cnt[k]--;
                    m_mem[k][m_cnt[k]] = 8'h00;
                end else e = 1'b1;
            end else if (x.wr_en) begin
                if (int'(x.wr_addr) < d) m_mem[k][x.wr_addr] = x.wr_data;
                else e = 1'b1;
            end
            e_err[k] = e;
            e_ra[k] = m_rd(k, int'(x.ra));
            e_rb[k] = m_rd(k, int'(x.rb));
        end
    endtask

    task automatic check_dut(input int k);
        logic [7:0] a, b;
        logic [4:0] c;
        logic [3:0] p;
        logic f, em, bz, er;
        if (k == 0) begin
            a = ia.rd_data_a; b = ia.rd_data_b; c = ia.count; p = ia.wr_ptr;
            f = ia.full; em = ia.empty; bz = ia.busy; er = ia.err;
        end else begin
            a = ib.rd_data_a; b = ib.rd_data_b; c = ib.count; p = ib.wr_ptr;
            f = ib.full; em = ib.empty; bz = ib.busy; er = ib.err;
        end
        chk($sformatf("d%0d rd_data_a", k), a, e_ra[k]);
        chk($sformatf("d%0d rd_data_b", k), b, e_rb[k]);
        chk($sformatf("d%0d count", k), c, m_cnt[k]);
        chk($sformatf("d%0d wr_ptr", k), p, m_cnt[k] % 16);
        chk($sformatf("d%0d full", k), f, m_cnt[k] == dep[k]);
        chk($sformatf("d%0d empty", k), em, m_cnt[k] == 0);
        chk($sformatf("d%0d busy", k), bz, m_bl[k] > 0);
        chk($sformatf("d%0d err", k), er, e_err[k]);
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check_dut(0);
        check_dut(1);
    endtask

    function automatic in_t mk(input logic we, input int addr, input int data, input logic pu,
                               input logic po, input logic cl, input int ra, input int rb);
        in_t x;
        x.wr_en = we; x.wr_addr = 4'(addr); x.wr_data = 8'(data);
        x.push = pu; x.pop = po; x.clr_req = cl; x.ra = 4'(ra); x.rb = 4'(rb);
        return x;
    endfunction

    task automatic drive(input int k, input in_t x);
        inp[k] = x;
        tick();
        inp[k] = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((ia.busy || ib.busy) && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk("wait_idle timeout", 1, 0);
    endtask

    task automatic read_all(input int k);
        for (int a = 0; a < 16; a++) drive(k, mk(0, 0, 0, 0, 0, 0, a, 15 - a));
        drive(k, '0);
    endtask

    initial begin
        int n;
        inp[0] = '0;
        inp[1] = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n = 0;
        while (ia.busy && n < 40) begin
            tick();
            n++;
        end
        chk("busy_len", n, 16);
        wait_idle();
        read_all(0);
        read_all(1);
        drive(0, mk(0, 0, 8'h41, 1, 0, 0, 0, 0));
        drive(0, mk(0, 0, 8'h42, 1, 0, 0, 0, 0));
        drive(0, mk(0, 0, 8'h43, 1, 0, 0, 0, 1));
        drive(0, mk(0, 0, 0, 0, 0, 0, 0, 1));
        chk("append rd_b addr1", ia.rd_data_b, 8'h42);
        drive(0, mk(0, 0, 0, 0, 1, 0, 2, 2));
        drive(0, mk(0, 0, 0, 0, 0, 0, 2, 0));
        chk("pop wr_ptr", ia.wr_ptr, 2);
        drive(0, mk(0, 0, 0, 0, 0, 1, 0, 0));
        wait_idle();
        for (int i = 0; i < 17; i++) drive(0, mk(0, 0, $urandom_range(1, 255), 1, 0, 0, i, 15 - i));
        chk("overflow wr_ptr", ia.wr_ptr, 0);
        chk("overflow count", ia.count, 16);
        for (int i = 0; i < 17; i++) drive(0, mk(0, 0, 0, 0, 1, 0, i, i));
        drive(0, mk(0, 0, 8'h55, 1, 0, 0, 0, 0));
        drive(0, mk(1, 7, 8'h99, 1, 0, 0, 7, 1));
        drive(0, mk(0, 0, 0, 0, 0, 0, 7, 1));
        drive(0, mk(1, 5, 8'h3c, 0, 0, 0, 5, 5));
        for (int i = 0; i < 5; i++) drive(0, mk(0, 0, $urandom_range(1, 255), 1, 0, 0, i, i));
        drive(0, mk(0, 0, 0, 0, 0, 1, 0, 0));
        drive(0, mk(0, 0, 8'h77, 1, 0, 0, 0, 0));
        wait_idle();
        read_all(0);
        drive(1, mk(1, 15, 8'hab, 0, 0, 0, 14, 15));
        drive(1, mk(1, 11, 8'hcd, 0, 0, 0, 11, 14));
        for (int i = 0; i < 13; i++) drive(1, mk(0, 0, $urandom_range(0, 255), 1, 0, 0, i, 11));
        read_all(1);
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int k = 0; k < 2; k++) begin
                inp[k] = mk($urandom_range(0, 3) == 0, $urandom_range(0, 15), $urandom_range(0, 255),
                            $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                            $urandom_range(0, 59) == 0, $urandom_range(0, 15), $urandom_range(0, 15));
            end
            tick();
        end
        rst = 1'b0;
        inp[0] = '0;
        inp[1] = '0;
        wait_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
